// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/stall controller.
package pipeline_stall_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

  typedef enum logic {
    StIdle,
    StBusy
  } md_state_e;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div unit busy timer: loads a cycle count on start and counts down to idle.
module md_busy_timer
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCycles + 1);

  md_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (start) begin
      // A start while busy reloads the timer; upstream stalling should prevent it.
      state_d = StBusy;
      cnt_d   = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
        end
        StBusy: begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = start | (cnt_q != '0);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall controller: compares D-stage Tuse against E/M Tnew, gates PC/F-D writes,
// bubbles D/E, tracks the mult/div busy window and counts stall cycles.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_rs_Tuse,
  input  logic [1:0]       D_rt_Tuse,
  input  logic             D_is_md,
  input  logic [4:0]       E_A3,
  input  logic [1:0]       E_Tnew,
  input  logic [4:0]       M_A3,
  input  logic [1:0]       M_Tnew,
  input  logic             E_md_start,
  input  logic             E_md_is_div,
  output logic             PC_WrEn,
  output logic             FD_WrEn,
  output logic             DE_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic stall_rs, stall_rt, stall_md, stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (E_md_start),
    .is_div (E_md_is_div),
    .busy   (md_busy)
  );

  // Tuse==3 and Tnew==0 fall out of the unsigned compare without special cases.
  always_comb begin
    stall_rs = (D_rs != REG_ZERO) &&
               (((D_rs == E_A3) && (D_rs_Tuse < E_Tnew)) ||
                ((D_rs == M_A3) && (D_rs_Tuse < M_Tnew)));
    stall_rt = (D_rt != REG_ZERO) &&
               (((D_rt == E_A3) && (D_rt_Tuse < E_Tnew)) ||
                ((D_rt == M_A3) && (D_rt_Tuse < M_Tnew)));
    stall_md = D_is_md & md_busy;
    stall    = stall_rs | stall_rt | stall_md;
  end

  assign PC_WrEn  = ~stall;
  assign FD_WrEn  = ~stall;
  assign DE_flush = stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
